// File: rtl/gf_modexp_ctrl.sv
// Square-and-multiply controller for a GF(2^M) modmul unit.
// Computes base^exponent mod polynom through modmul's enable/valid handshake.
module gf_modexp_ctrl #(
  parameter int M     = 11,
  parameter int EXP_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [M:0]       polynom,
  input  logic [M-1:0]     base,
  input  logic [EXP_W-1:0] exponent,
  output logic             busy,
  output logic             done,
  output logic [M-1:0]     result,
  output logic [M:0]       mm_polynom,
  output logic [M-1:0]     mm_a,
  output logic [M-1:0]     mm_b,
  output logic             mm_enable,
  input  logic [M-1:0]     mm_dataout,
  input  logic             mm_valid
);

  localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IW-1:0] IMAX = IW'(EXP_W - 1);
  localparam logic [M-1:0] ONE = M'(1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SQR_REQ,
    SQR_GAP,
    MUL_REQ,
    MUL_GAP,
    NEXT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]    i_q, i_d;
  logic [M-1:0]     acc_q, acc_d;
  logic [M-1:0]     base_q, base_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [M:0]       poly_q, poly_d;
  logic [M-1:0]     res_q, res_d;
  logic [M-1:0]     a_q, a_d;
  logic [M-1:0]     b_q, b_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      acc_q   <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      poly_q  <= '0;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      poly_q  <= poly_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    acc_d   = acc_q;
    base_d  = base_q;
    exp_d   = exp_q;
    poly_d  = poly_q;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          poly_d  = polynom;
          base_d  = base;
          exp_d   = exponent;
          i_d     = IMAX;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (exp_q[i_q]) begin
          acc_d = base_q;
          if (i_q == '0) begin
            state_d = DONE;
          end else begin
            i_d     = i_q - 1'b1;
            state_d = SQR_REQ;
          end
        end else if (i_q == '0) begin
          acc_d   = ONE;
          state_d = DONE;
        end else begin
          i_d = i_q - 1'b1;
        end
      end
      SQR_REQ: begin
        if (mm_valid) begin
          acc_d   = mm_dataout;
          state_d = SQR_GAP;
        end
      end
      SQR_GAP: begin
        if (!mm_valid) begin
          state_d = exp_q[i_q] ? MUL_REQ : NEXT;
        end
      end
      MUL_REQ: begin
        if (mm_valid) begin
          acc_d   = mm_dataout;
          state_d = MUL_GAP;
        end
      end
      MUL_GAP: begin
        if (!mm_valid) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (i_q == '0) begin
          state_d = DONE;
        end else begin
          i_d     = i_q - 1'b1;
          state_d = SQR_REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Operands are registered so they stay put for the whole request.
    if (state_d == SQR_REQ) begin
      a_d = acc_d;
      b_d = acc_d;
    end else if (state_d == MUL_REQ) begin
      a_d = acc_d;
      b_d = base_q;
    end

    if (state_d == DONE) begin
      res_d = acc_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign result     = res_q;
  assign mm_polynom = poly_q;
  assign mm_a       = a_q;
  assign mm_b       = b_q;
  assign mm_enable  = (state_q == SQR_REQ) || (state_q == MUL_REQ);

endmodule

// File: tb/tb_gf_modexp_ctrl.sv
// Bench for gf_modexp_ctrl with a behavioural modmul of programmable latency.
// Directed vectors plus sequences for random latency, mid-op start and reset.
module tb_gf_modexp_ctrl;

  localparam int M     = 11;
  localparam int EXP_W = 11;
  localparam logic [M:0] POLY = 12'b100000000101;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [M:0]       polynom = POLY;
  logic [M-1:0]     base = '0;
  logic [EXP_W-1:0] exponent = '0;
  logic             busy;
  logic             done;
  logic [M-1:0]     result;
  logic [M:0]       mm_polynom;
  logic [M-1:0]     mm_a;
  logic [M-1:0]     mm_b;
  logic             mm_enable;
  logic [M-1:0]     mm_dataout = '0;
  logic             mm_valid = 1'b0;

  gf_modexp_ctrl #(.M(M), .EXP_W(EXP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .polynom    (polynom),
    .base       (base),
    .exponent   (exponent),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .mm_polynom (mm_polynom),
    .mm_a       (mm_a),
    .mm_b       (mm_b),
    .mm_enable  (mm_enable),
    .mm_dataout (mm_dataout),
    .mm_valid   (mm_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                          input logic [M-1:0] b,
                                          input logic [M:0] p);
    logic [M:0] r;
    r = '0;
    for (int k = M - 1; k >= 0; k--) begin
      r = r << 1;
      if (r[M]) r = r ^ p;
      if (b[k]) r = r ^ {1'b0, a};
    end
    return r[M-1:0];
  endfunction

  function automatic logic [M-1:0] gf_pow(input logic [M-1:0] b,
                                          input int e);
    logic [M-1:0] r;
    r = M'(1);
    for (int k = 0; k < e; k++) r = gf_mul(r, b, POLY);
    return r;
  endfunction

  // behavioural modmul
  bit rnd = 1'b0;
  int fix_lat = 1;
  int mdl_cnt = 0;
  int mdl_hold = 0;
  bit mdl_run = 1'b0;
  int prod_cnt = 0;

  function automatic int pick_lat();
    return rnd ? int'($urandom_range(20, 1)) : fix_lat;
  endfunction

  function automatic int pick_hold();
    return rnd ? int'($urandom_range(3, 0)) : 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mm_valid <= 1'b0;
      mdl_run  <= 1'b0;
      mdl_cnt  <= 0;
      mdl_hold <= 0;
    end else if (mm_valid) begin
      if (!mm_enable) begin
        if (mdl_hold == 0) begin
          mm_valid <= 1'b0;
          mdl_run  <= 1'b0;
        end else begin
          mdl_hold <= mdl_hold - 1;
        end
      end
    end else if (mm_enable) begin
      if (!mdl_run) begin
        mdl_run  <= 1'b1;
        mdl_cnt  <= pick_lat();
        mdl_hold <= pick_hold();
        prod_cnt <= prod_cnt + 1;
      end else if (mdl_cnt <= 1) begin
        mm_valid   <= 1'b1;
        mm_dataout <= gf_mul(mm_a, mm_b, mm_polynom);
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  // handshake monitor
  logic            prev_en = 1'b0;
  logic            prev_valid = 1'b0;
  logic [3*M:0]    prev_ops = '0;
  int              viol = 0;
  int              done_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (mm_enable && prev_en && {mm_polynom, mm_a, mm_b} != prev_ops)
        viol <= viol + 1;
      else if (mm_enable && !prev_en && mm_valid)
        viol <= viol + 1;
      else if (!mm_enable && prev_en && !prev_valid)
        viol <= viol + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
    prev_en    <= mm_enable;
    prev_valid <= mm_valid;
    prev_ops   <= {mm_polynom, mm_a, mm_b};
  end

  task automatic run_op(input logic [M-1:0] b, input logic [EXP_W-1:0] e,
                        input int poke, output logic [M-1:0] r,
                        output int np, output int nd, output bit to);
    int p0, d0;
    @(negedge clk);
    p0 = prod_cnt;
    d0 = done_cnt;
    base = b;
    exponent = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to = 1'b1;
    r = '0;
    for (int c = 0; c < 4000; c++) begin
      if (done) begin
        to = 1'b0;
        r = result;
        break;
      end
      start = (c == poke);
      if (c == poke) begin
        base = 11'h7;
        exponent = 11'h3;
      end
      @(negedge clk);
      start = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    np = prod_cnt - p0;
    nd = done_cnt - d0;
  endtask

  typedef struct {
    logic [M-1:0]     b;
    logic [EXP_W-1:0] e;
    int               lat;
    logic [M-1:0]     res;
    int               prods;
  } vec_t;

  vec_t vecs[10];

  logic [M-1:0] r;
  int np, nd, d0;
  bit to;

  initial begin
    vecs[0] = '{11'h002, 11'd11,   1, 11'h005, 5};
    vecs[1] = '{11'h123, 11'd0,    3, 11'h001, 0};
    vecs[2] = '{11'h429, 11'd1,    5, 11'h429, 0};
    vecs[3] = '{11'h002, 11'd2,    2, 11'h004, 1};
    vecs[4] = '{11'h002, 11'd3,   20, 11'h008, 2};
    vecs[5] = '{11'h002, 11'd10,   4, 11'h400, 4};
    vecs[6] = '{11'h003, 11'd2,    7, 11'h005, 1};
    vecs[7] = '{11'h002, 11'd12,   1, 11'h00A, 4};
    vecs[8] = '{11'h002, 11'd22,   9, 11'h011, 6};
    vecs[9] = '{11'h000, 11'h7FF,  2, 11'h000, 20};

    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_en", 32'(mm_enable), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_ops", 32'({mm_a, mm_b}), 0);
    chk("rst_poly", 32'(mm_polynom), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 10; v++) begin
      fix_lat = vecs[v].lat;
      run_op(vecs[v].b, vecs[v].e, -1, r, np, nd, to);
      chk($sformatf("v%0d_timeout", v), 32'(to), 0);
      chk($sformatf("v%0d_result", v), 32'(r), 32'(vecs[v].res));
      chk($sformatf("v%0d_prods", v), 32'(np), 32'(vecs[v].prods));
      chk($sformatf("v%0d_done", v), 32'(nd), 1);
    end
    chk("result_held", 32'(result), 0);
    chk("poly_latched", 32'(mm_polynom), 32'(POLY));

    rnd = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_op(11'h002, 11'd11, -1, r, np, nd, to);
      chk($sformatf("rnd%0d_result", k), 32'(r), 32'h005);
      chk($sformatf("rnd%0d_prods", k), 32'(np), 5);
      chk($sformatf("rnd%0d_done", k), 32'(nd), 1);
    end

    run_op(11'h002, 11'd11, 6, r, np, nd, to);
    chk("poke_result", 32'(r), 32'h005);
    chk("poke_prods", 32'(np), 5);
    chk("poke_done", 32'(nd), 1);

    @(negedge clk);
    d0 = done_cnt;
    base = 11'h002;
    exponent = 11'h7FF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (mm_enable) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    chk("rst_wait_en", 32'(to), 0);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_en", 32'(mm_enable), 0);
    repeat (4) @(negedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    chk("abort_result", 32'(result), 0);
    @(negedge clk);
    reset = 1'b1;
    run_op(11'h002, 11'd11, -1, r, np, nd, to);
    chk("post_rst_result", 32'(r), 32'h005);
    chk("post_rst_done", 32'(nd), 1);

    rnd = 1'b0;
    fix_lat = 3;
    run_op(11'h002, 11'h7FF, -1, r, np, nd, to);
    chk("pow7ff_hand", 32'(r), 32'h001);
    chk("pow7ff_ref", 32'(r), 32'(gf_pow(11'h002, 2047)));
    chk("pow7ff_prods", 32'(np), 20);

    chk("protocol", 32'(viol), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
